// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants and destination-tag type for forwarding/hazard logic
package pipe_pkg;

    localparam int RN_W = 5;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_EXALU  = 2'b01;
    localparam logic [1:0] FWD_MEMALU = 2'b10;
    localparam logic [1:0] FWD_MEMLD  = 2'b11;

    typedef struct packed {
        logic            wreg;
        logic            m2reg;
        logic [RN_W-1:0] rn;
    } dest_tag_t;

    localparam dest_tag_t TAG_BUBBLE = '0;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - combinational forwarding select for a single source operand
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int REG_W = RN_W
) (
    input  logic             id_valid,
    input  logic             use_src,
    input  logic [REG_W-1:0] src,
    input  dest_tag_t        e_tag,
    input  dest_tag_t        m_tag,
    output logic [1:0]       sel
);

    // Youngest producer wins; a load in EX cannot forward, so it falls through to MEM.
    always_comb begin
        sel = FWD_RF;
        if (id_valid && use_src && (src != '0)) begin
            if (e_tag.wreg && !e_tag.m2reg && (e_tag.rn == src)) begin
                sel = FWD_EXALU;
            end else if (m_tag.wreg && (m_tag.rn == src)) begin
                sel = m_tag.m2reg ? FWD_MEMLD : FWD_MEMALU;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - ID-stage forwarding and load-use stall controller; counters under FWD_HAZARD_STATS_EN
module fwd_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_W = RN_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic [REG_W-1:0] id_rn,
    input  logic             flush,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    dest_tag_t e_tag;
    dest_tag_t m_tag;
    dest_tag_t id_tag;
    logic      issue;
    logic      hit_rs;
    logic      hit_rt;

    assign id_tag = '{wreg: id_wreg, m2reg: id_m2reg, rn: id_rn};

    // A stalled or flushed instruction must not enter EX; it becomes a bubble there.
    assign issue = id_valid && !stall && !flush;

    fwd_sel #(.REG_W(REG_W)) u_sel_a (
        .id_valid (id_valid),
        .use_src  (id_use_rs),
        .src      (id_rs),
        .e_tag    (e_tag),
        .m_tag    (m_tag),
        .sel      (fwda)
    );

    fwd_sel #(.REG_W(REG_W)) u_sel_b (
        .id_valid (id_valid),
        .use_src  (id_use_rt),
        .src      (id_rt),
        .e_tag    (e_tag),
        .m_tag    (m_tag),
        .sel      (fwdb)
    );

    // Load in EX whose result ID needs right now: data only exists after MEM, so hold one cycle.
    always_comb begin
        hit_rs = id_use_rs && (e_tag.rn == id_rs);
        hit_rt = id_use_rt && (e_tag.rn == id_rt);
        stall  = id_valid && e_tag.wreg && e_tag.m2reg && (e_tag.rn != '0) && (hit_rs || hit_rt);
    end

    // Shadow the EX/MEM destination tags, advancing one stage per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_tag <= TAG_BUBBLE;
            m_tag <= TAG_BUBBLE;
        end else begin
            m_tag <= e_tag;
            e_tag <= issue ? id_tag : TAG_BUBBLE;
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_q;
    logic             fwd_used;

    assign fwd_used = ((fwda != FWD_RF) || (fwdb != FWD_RF)) && !stall;

    // Saturating event counters for stall cycles and cycles that consumed a forwarded value.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (fwd_used && (fwd_cnt_q != '1)) begin
                fwd_cnt_q <= fwd_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule
